// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I/RV32M execute stage; single-cycle base ops, iterative radix-2 mul/div, valid/ready on both sides
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [1:0]      i_alu_op,
    input  logic [2:0]      i_funct3,
    input  logic [6:0]      i_funct7,
    input  logic            i_is_rtype,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [XLEN-1:0]     r_result, r_hi, r_lo, r_b;
    logic [SHAMT_W-1:0]  r_cnt;
    logic [2:0]          r_f3;
    logic                r_neg_p, r_neg_r;

    logic                w_accept, w_m_enc, w_is_m, w_div, w_sa, w_sb, w_neg_a, w_neg_b;
    logic                w_div0, w_ovf, w_special, w_ge;
    logic [SHAMT_W-1:0]  w_shamt;
    logic [XLEN-1:0]     w_base, w_mag_a, w_mag_b, w_spec_val, w_diff, w_fix;
    logic [XLEN:0]       w_sum, w_sh;
    logic [2*XLEN-1:0]   w_prod_s;

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_zero      = (r_result == '0);

    assign w_accept  = i_in_valid & o_in_ready;
    assign w_m_enc   = (i_alu_op == 2'b10) && i_is_rtype && (i_funct7 == 7'b0000001);
    assign w_is_m    = M_EXT && w_m_enc;
    assign w_div     = i_funct3[2];
    assign w_shamt   = i_op_b[SHAMT_W-1:0];

    // Signedness of each operand: MULH both, MULHSU only rs1, DIV/REM both, unsigned variants neither
    assign w_sa      = w_div ? ~i_funct3[0] : (i_funct3[1] ^ i_funct3[0]);
    assign w_sb      = w_div ? ~i_funct3[0] : (i_funct3[1:0] == 2'b01);
    assign w_neg_a   = w_sa & i_op_a[XLEN-1];
    assign w_neg_b   = w_sb & i_op_b[XLEN-1];
    assign w_mag_a   = w_neg_a ? -i_op_a : i_op_a;
    assign w_mag_b   = w_neg_b ? -i_op_b : i_op_b;

    // Divide-by-zero and signed overflow bypass the iterative datapath entirely
    assign w_div0     = w_div && (i_op_b == '0);
    assign w_ovf      = w_div && !i_funct3[0] && (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&i_op_b);
    assign w_special  = w_div0 | w_ovf;
    assign w_spec_val = w_div0 ? (i_funct3[1] ? i_op_a : '1) : (i_funct3[1] ? '0 : i_op_a);

    // One shift-add step: {hi,lo} shifts right with the carry of hi + (lo[0] ? b : 0)
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // One restoring-divide step; the remainder stays below the divisor so XLEN bits suffice
    assign w_sh   = {r_hi, r_lo[XLEN-1]};
    assign w_ge   = (w_sh >= {1'b0, r_b});
    assign w_diff = w_sh[XLEN-1:0] - r_b;

    assign w_prod_s = r_neg_p ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_fix    = r_f3[2] ? (r_f3[1] ? (r_neg_r ? -r_hi : r_hi) : (r_neg_p ? -r_lo : r_lo))
                              : ((r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN]);

    // Single-cycle result for every non-M encoding
    always_comb begin
        w_base = i_op_a + i_op_b;
        case (i_alu_op)
            2'b01: w_base = i_op_a - i_op_b;
            2'b11: w_base = i_op_b;
            2'b10: begin
                case (i_funct3)
                    3'b000: w_base = (i_is_rtype && i_funct7 == 7'b0100000) ? i_op_a - i_op_b : i_op_a + i_op_b;
                    3'b001: w_base = i_op_a << w_shamt;
                    3'b010: w_base = {{(XLEN-1){1'b0}}, $signed(i_op_a) < $signed(i_op_b)};
                    3'b011: w_base = {{(XLEN-1){1'b0}}, i_op_a < i_op_b};
                    3'b100: w_base = i_op_a ^ i_op_b;
                    3'b101: w_base = i_funct7[5] ? $unsigned($signed(i_op_a) >>> w_shamt) : i_op_a >> w_shamt;
                    3'b110: w_base = i_op_a | i_op_b;
                    default: w_base = i_op_a & i_op_b;
                endcase
                if (w_m_enc) w_base = i_op_a + i_op_b;
            end
            default: w_base = i_op_a + i_op_b;
        endcase
    end

    // Next state: flush wins over any accept or progress in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (w_is_m && !w_special) ? S_BUSY : S_DONE;
            S_BUSY: if (r_cnt == SHAMT_W'(XLEN-1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (i_out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_flush) w_next = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Datapath: load on accept, iterate while busy, sign-fix into the result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg_p  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (!i_flush) begin
            if (w_accept) begin
                r_f3    <= i_funct3;
                r_cnt   <= '0;
                r_hi    <= '0;
                r_lo    <= w_div ? w_mag_a : w_mag_b;
                r_b     <= w_div ? w_mag_b : w_mag_a;
                r_neg_p <= w_neg_a ^ w_neg_b;
                r_neg_r <= w_neg_a;
                if (!w_is_m)        r_result <= w_base;
                else if (w_special) r_result <= w_spec_val;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
                r_hi  <= r_f3[2] ? (w_ge ? w_diff : w_sh[XLEN-1:0]) : w_sum[XLEN:1];
                r_lo  <= r_f3[2] ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};
            end else if (r_state == S_FIX) begin
                r_result <= w_fix;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized and directed checks of alu_exec_unit against a behavioural RV32IM model
module tb_alu_exec_unit;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, is_rtype = 1'b0;
    logic        in_ready, out_valid, zero;
    logic [1:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] op_a = '0, op_b = '0, result;
    int          total = 0, bad = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_alu_op(alu_op), .i_funct3(funct3), .i_funct7(funct7), .i_is_rtype(is_rtype),
        .i_op_a(op_a), .i_op_b(op_b), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_result(result), .o_zero(zero)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                          input logic rt, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        int          sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return b;
        if (rt && f7 == 7'b0000001) begin
            case (f3)
                3'd0: return a * b;
                3'd1: begin p = sa * sb; return p[63:32]; end
                3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
                3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
                3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
                3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
                3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
                default: begin if (b == 0) return a; return a % b; end
            endcase
        end
        case (f3)
            3'd0: return (rt && f7 == 7'b0100000) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return {31'b0, sa < sb};
            3'd3: return {31'b0, a < b};
            3'd4: return a ^ b;
            3'd5: return f7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic rt, input logic [31:0] a, input logic [31:0] b);
        if (!(op == 2'b10 && rt && f7 == 7'b0000001)) return 1;
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return 34;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic rt, input logic [31:0] a, input logic [31:0] b);
        alu_op = op; funct3 = f3; funct7 = f7; is_rtype = rt; op_a = a; op_b = b;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic rt,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int lat);
        drive(op, f3, f7, rt, a, b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = result;
        z = zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (result !== 32'h0)   begin bad++; $display("FAIL rst_result: got %h want 0", result); end
        total++; if (zero !== 1'b1)      begin bad++; $display("FAIL rst_zero: got %b want 1", zero); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed;
        vec_t        v [0:14];
        logic [31:0] res;
        logic        z;
        int          lat;
        v = '{
            '{2'b10, 3'd0, 7'h00, 1'b1, 32'd5,        32'd7,        32'd12,       8'd1},
            '{2'b01, 3'd0, 7'h00, 1'b1, 32'h1234,     32'h1234,     32'h0,        8'd1},
            '{2'b11, 3'd0, 7'h00, 1'b0, 32'h5,        32'hABCD0000, 32'hABCD0000, 8'd1},
            '{2'b10, 3'd5, 7'h20, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 8'd1},
            '{2'b10, 3'd5, 7'h20, 1'b0, 32'h80000000, 32'd4,        32'hF8000000, 8'd1},
            '{2'b10, 3'd3, 7'h00, 1'b1, 32'd1,        32'hFFFFFFFF, 32'd1,        8'd1},
            '{2'b10, 3'd2, 7'h00, 1'b1, 32'd1,        32'hFFFFFFFF, 32'd0,        8'd1},
            '{2'b10, 3'd3, 7'h01, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd34},
            '{2'b10, 3'd0, 7'h01, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        8'd34},
            '{2'b10, 3'd4, 7'h01, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 8'd34},
            '{2'b10, 3'd6, 7'h01, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 8'd34},
            '{2'b10, 3'd4, 7'h01, 1'b1, 32'd7,        32'd0,        32'hFFFFFFFF, 8'd1},
            '{2'b10, 3'd7, 7'h01, 1'b1, 32'd7,        32'd0,        32'd7,        8'd1},
            '{2'b10, 3'd4, 7'h01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1},
            '{2'b10, 3'd6, 7'h01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        8'd1}
        };
        for (int i = 0; i < 15; i++) begin
            do_op(v[i].op, v[i].f3, v[i].f7, v[i].rt, v[i].a, v[i].b, res, z, lat);
            total++; if (res !== v[i].exp) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, res, v[i].exp); end
            total++; if (z !== (v[i].exp == 0)) begin bad++; $display("FAIL dir%0d_zero: got %b want %b", i, z, v[i].exp == 0); end
            total++; if (lat != int'(v[i].lat)) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_random_base;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rt;
        logic [31:0] a, b, exp, res;
        logic        z;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            rt = 1'($urandom_range(0, 1));
            f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            exp = model(op, f3, f7, rt, a, b);
            do_op(op, f3, f7, rt, a, b, res, z, lat);
            total++; if (res !== exp || z !== (exp == 0) || lat != 1) begin
                bad++; $display("FAIL rb%0d op=%b f3=%0d: got %h z=%b lat=%0d want %h z=%b lat=1", i, op, f3, res, z, lat, exp, exp == 0);
            end
        end
    endtask

    task automatic test_random_muldiv;
        logic [2:0]  f3;
        logic [31:0] a, b, exp, res;
        logic        z;
        int          lat, elat;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'(i % 8);
            a  = ($urandom_range(0, 3) == 0) ? 32'(-$urandom_range(1, 1000)) : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 50));
                2: b = 32'(-$urandom_range(1, 50));
                default: b = $urandom;
            endcase
            exp  = model(2'b10, f3, 7'h01, 1'b1, a, b);
            elat = model_lat(2'b10, f3, 7'h01, 1'b1, a, b);
            do_op(2'b10, f3, 7'h01, 1'b1, a, b, res, z, lat);
            total++; if (res !== exp || z !== (exp == 0) || lat != elat) begin
                bad++; $display("FAIL rm%0d f3=%0d a=%h b=%h: got %h lat=%0d want %h lat=%0d", i, f3, a, b, res, lat, exp, elat);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp1, exp2;
        int          lat, stable_bad;
        exp1 = model(2'b10, 3'd1, 7'h01, 1'b1, 32'h12345678, 32'h9ABCDEF0);
        exp2 = model(2'b10, 3'd4, 7'h00, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0);
        drive(2'b10, 3'd1, 7'h01, 1'b1, 32'h12345678, 32'h9ABCDEF0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(2'b10, 3'd4, 7'h00, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0);
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        total++; if (lat != 34) begin bad++; $display("FAIL bp_latency: got %0d want 34", lat); end
        stable_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp1) stable_bad++;
            @(posedge clk); #1;
        end
        total++; if (stable_bad != 0 || result !== exp1) begin
            bad++; $display("FAIL bp_hold: got %0d unstable cycles result=%h want 0 result=%h", stable_bad, result, exp1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_no_reaccept: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== exp2) begin
            bad++; $display("FAIL bp_second: got vld=%b %h want 1 %h", out_valid, result, exp2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        logic [31:0] prev, res;
        logic        z;
        int          lat, seen;
        prev = model(2'b10, 3'd6, 7'h00, 1'b1, 32'h00FF0000, 32'h0000AA55);
        do_op(2'b10, 3'd6, 7'h00, 1'b1, 32'h00FF0000, 32'h0000AA55, res, z, lat);
        drive(2'b10, 3'd5, 7'h01, 1'b1, 32'd1000, 32'd7);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_idle: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        total++; if (result !== prev) begin bad++; $display("FAIL flush_keep: got %h want %h", result, prev); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_silent: got %0d valid cycles want 0", seen); end
        drive(2'b00, 3'd0, 7'h00, 1'b0, 32'd3, 32'd4);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        seen = 0;
        repeat (3) begin if (out_valid || !in_ready) seen++; @(posedge clk); #1; end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_over_accept: got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_reset_busy;
        int seen;
        drive(2'b10, 3'd0, 7'h01, 1'b1, 32'd12345, 32'd678);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            bad++; $display("FAIL rstbusy_now: got rdy=%b vld=%b res=%h z=%b want 1 0 0 1", in_ready, out_valid, result, zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        total++; if (seen != 0 || result !== 32'h0) begin
            bad++; $display("FAIL rstbusy_silent: got %0d valid cycles res=%h want 0 0", seen, result);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random_base;
        test_random_muldiv;
        test_back_to_back;
        test_flush;
        test_reset_busy;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
